uart_word_tx: RTL and testbench

// - Return path of the host UART link: serializes WORD_WIDTH-bit words (DATA/INFERENCE BRAM

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_byte_tx.sv | 104 ++++++++++
 rtl/uart_word_tx.sv | 117 +++++++++++
 tb/tb_uart_word_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the host link (transmit and receive paths).
//   tx_state_t         serializer states
//   UART_DATA_BITS     data bits per 8N1 frame
//   UART_CLKS_PER_BIT  default bit period in clk cycles (4 Mbaud at 100 MHz)
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 25;

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer.
//   clk_in     system clock
//   rst_in     synchronous, active-high reset
//   byte_in    byte to send, taken when valid_in && ready_out
//   valid_in   byte_in valid
//   ready_out  idle, or in the last cycle of a stop bit (allows gap-free frames)
//   tx_out     serial output, idle high
//
// state    | meaning
// TX_IDLE  | line high, waiting for a byte
// TX_START | start bit (low) for CLKS_PER_BIT cycles
// TX_DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// TX_STOP  | stop bit (high); on its last cycle a new byte may be taken
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] byte_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx_out
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             baud_wrap;

    assign baud_wrap = (baud_cnt == CNT_MAX);

    // Accepting on the final stop-bit cycle makes the next start bit follow
    // directly, so the frames of one word run back-to-back.
    assign ready_out = (state == TX_IDLE) || ((state == TX_STOP) && baud_wrap);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= TX_IDLE;
            tx_out   <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
        end else begin
            if ((state == TX_IDLE) || baud_wrap) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end

            case (state)
                TX_IDLE: begin
                    if (valid_in) begin
                        shift_q <= byte_in;
                        state   <= TX_START;
                        tx_out  <= 1'b0;
                    end
                end
                TX_START: begin
                    if (baud_wrap) begin
                        state   <= TX_DATA;
                        bit_idx <= '0;
                        tx_out  <= shift_q[0];
                    end
                end
                TX_DATA: begin
                    if (baud_wrap) begin
                        if (bit_idx == BIT_LAST) begin
                            state  <= TX_STOP;
                            tx_out <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_out  <= shift_q[1];
                        end
                    end
                end
                TX_STOP: begin
                    if (baud_wrap) begin
                        if (valid_in) begin
                            shift_q <= byte_in;
                            state   <= TX_START;
                            tx_out  <= 1'b0;
                        end else begin
                            state   <= TX_IDLE;
                            tx_out  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= TX_IDLE;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Word-to-UART return path: sends WORD_WIDTH-bit words as 8N1 frames,
// low byte first, data bits LSB first.
//   clk_in          system clock
//   rst_in          synchronous, active-high reset
//   word_in         word to transmit, captured on acceptance
//   word_valid_in   word_in valid
//   word_ready_out  block can accept a word this cycle (registered)
//   tx_out          UART serial output, idle high
//   busy_out        high while any frame of the current word is in flight
// Optional build macro UART_WORD_TX_CHECKSUM_EN appends one frame carrying
// the XOR of all bytes of the word.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int WORD_WIDTH   = 64,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid_in,
    output logic                  word_ready_out,
    output logic                  tx_out,
    output logic                  busy_out
);

    localparam int N_BYTES = WORD_WIDTH / 8;
`ifdef UART_WORD_TX_CHECKSUM_EN
    localparam int N_FRAMES = N_BYTES + 1;
`else
    localparam int N_FRAMES = N_BYTES;
`endif
    localparam int               IDX_W    = $clog2(N_FRAMES + 1);
    localparam logic [IDX_W-1:0] IDX_DONE = IDX_W'(N_FRAMES);

    logic [WORD_WIDTH-1:0] shift_q;
    logic [IDX_W-1:0]      byte_idx;
    logic [7:0]            byte_data;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  word_fire;
    logic                  byte_fire;
    logic                  all_sent;
`ifdef UART_WORD_TX_CHECKSUM_EN
    localparam logic [IDX_W-1:0] IDX_CSUM = IDX_W'(N_BYTES);
    logic [7:0]            csum_q;
`endif

    assign word_fire = word_valid_in && word_ready_out;
    assign all_sent  = (byte_idx == IDX_DONE);
    assign byte_fire = byte_valid && byte_ready;

    // Byte 0 goes straight from word_in so the start bit falls the cycle
    // after acceptance; later bytes come from the shift register.
    always_comb begin
        byte_data  = shift_q[7:0];
        byte_valid = 1'b0;
        if (word_ready_out) begin
            byte_data  = word_in[7:0];
            byte_valid = word_valid_in;
        end else if (busy_out && !all_sent) begin
            byte_valid = 1'b1;
`ifdef UART_WORD_TX_CHECKSUM_EN
            if (byte_idx == IDX_CSUM) begin
                byte_data = csum_q;
            end
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            word_ready_out <= 1'b1;
            busy_out       <= 1'b0;
            byte_idx       <= '0;
            shift_q        <= '0;
`ifdef UART_WORD_TX_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else if (word_fire) begin
            word_ready_out <= 1'b0;
            busy_out       <= 1'b1;
            byte_idx       <= IDX_W'(1);
            shift_q        <= word_in >> 8;
`ifdef UART_WORD_TX_CHECKSUM_EN
            csum_q         <= word_in[7:0];
`endif
        end else if (busy_out) begin
            if (byte_fire) begin
                byte_idx <= byte_idx + IDX_W'(1);
                shift_q  <= shift_q >> 8;
`ifdef UART_WORD_TX_CHECKSUM_EN
                // Once the data bytes are gone the shift register is zero,
                // so the checksum frame leaves csum_q unchanged.
                csum_q   <= csum_q ^ shift_q[7:0];
`endif
            end else if (all_sent && byte_ready) begin
                // Last stop-bit cycle of the final frame.
                word_ready_out <= 1'b1;
                busy_out       <= 1'b0;
                byte_idx       <= '0;
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .byte_in   (byte_data),
        .valid_in  (byte_valid),
        .ready_out (byte_ready),
        .tx_out    (tx_out)
    );

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: random words, expected bytes queued at acceptance,
// a mid-bit sampling UART decoder pops and compares each received frame.
`timescale 1ns/1ps
module tb_uart_word_tx;

    localparam int WW  = 64;
    localparam int CPB = 25;
`ifdef UART_WORD_TX_CHECKSUM_EN
    localparam int N_FR = WW / 8 + 1;
`else
    localparam int N_FR = WW / 8;
`endif
    localparam int WORD_CYCLES = N_FR * 10 * CPB;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [WW-1:0] word_in;
    logic          word_valid_in;
    logic          word_ready_out;
    logic          tx_out;
    logic          busy_out;

    int   cyc       = 0;
    int   n_pass    = 0;
    int   n_total   = 0;
    int   rst_epoch = 0;
    logic [7:0] exp_q[$];

    uart_word_tx #(
        .WORD_WIDTH   (WW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .word_in        (word_in),
        .word_valid_in  (word_valid_in),
        .word_ready_out (word_ready_out),
        .tx_out         (tx_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: bytes in transmit order, low byte first, optional XOR frame.
    task automatic push_word(input logic [WW-1:0] w);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < WW / 8; k++) begin
            exp_q.push_back(w[8*k +: 8]);
            x = x ^ w[8*k +: 8];
        end
`ifdef UART_WORD_TX_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic send_word(input logic [WW-1:0] w, output int acc_cyc);
        int t;
        word_in       = w;
        word_valid_in = 1'b1;
        t = 0;
        while (word_ready_out !== 1'b1 && t < 3 * WORD_CYCLES) begin
            @(negedge clk_in);
            t++;
        end
        if (word_ready_out !== 1'b1) begin
            n_total++;
            $display("FAIL accept_timeout: ready stayed %b for %0d cycles", word_ready_out, t);
            word_valid_in = 1'b0;
            acc_cyc = -1;
            return;
        end
        push_word(w);
        @(negedge clk_in);
        acc_cyc       = cyc;
        word_valid_in = 1'b0;
        check("tx_start_after_accept", 64'(tx_out), 64'd0);
        check("ready_low_after_accept", 64'(word_ready_out), 64'd0);
        check("busy_after_accept", 64'(busy_out), 64'd1);
    endtask

    // Counts cycles with ready low; with jitter the source scribbles on
    // word_in/valid while the block is busy.
    task automatic wait_ready(input bit jitter, output int lc);
        lc = 0;
        while (word_ready_out !== 1'b1 && lc < 2 * WORD_CYCLES) begin
            lc++;
            if (jitter) begin
                word_in       = {$urandom, $urandom};
                word_valid_in = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk_in);
        end
        if (jitter) word_valid_in = 1'b0;
        check("ready_low_cycles", 64'(lc), 64'(WORD_CYCLES));
        check("idle_gap_tx_high", 64'(tx_out), 64'd1);
        check("idle_gap_not_busy", 64'(busy_out), 64'd0);
    endtask

    initial begin : monitor
        int         ep;
        logic [7:0] b;
        logic [7:0] e;
        logic       ok_start;
        logic       ok_stop;
        forever begin
            @(negedge clk_in);
            if (rst_in === 1'b0 && tx_out === 1'b0) begin
                ep = rst_epoch;
                repeat (CPB / 2) @(negedge clk_in);
                ok_start = (tx_out === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk_in);
                    b[i] = tx_out;
                end
                repeat (CPB) @(negedge clk_in);
                ok_stop = (tx_out === 1'b1);
                if (ep == rst_epoch) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_frame: got byte %0h with nothing expected", b);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_frame", {54'd0, ok_start, ok_stop, b}, {54'd0, 1'b1, 1'b1, e});
                    end
                end
            end
        end
    end

    initial begin
        int a;
        int bcyc;
        int lc;
        int bad;
        int t;
        logic [WW-1:0] wa;
        logic [WW-1:0] wb;

        rst_in        = 1'b1;
        word_in       = '0;
        word_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("reset_tx", 64'(tx_out), 64'd1);
        check("reset_ready", 64'(word_ready_out), 64'd1);
        check("reset_busy", 64'(busy_out), 64'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        send_word(64'h0706050403020100, a);
        wait_ready(1'b0, lc);

        for (int i = 0; i < 4; i++) begin
            send_word({$urandom, $urandom}, a);
            wait_ready(1'b1, lc);
            repeat ($urandom_range(0, 5)) @(negedge clk_in);
        end

        // Back-to-back: B held valid while A is in flight.
        wa = {$urandom, $urandom};
        wb = {$urandom, $urandom};
        send_word(wa, a);
        word_in       = wb;
        word_valid_in = 1'b1;
        wait_ready(1'b0, lc);
        send_word(wb, bcyc);
        check("b2b_accept_spacing", 64'(bcyc - a), 64'(WORD_CYCLES + 1));
        wait_ready(1'b0, lc);

        // Reset during byte 3 data bits.
        send_word({$urandom, $urandom}, a);
        repeat (3 * 10 * CPB + 3 * CPB) @(negedge clk_in);
        rst_in = 1'b1;
        exp_q.delete();
        rst_epoch++;
        @(negedge clk_in);
        check("midreset_tx", 64'(tx_out), 64'd1);
        check("midreset_ready", 64'(word_ready_out), 64'd1);
        check("midreset_busy", 64'(busy_out), 64'd0);
        rst_in = 1'b0;
        bad = 0;
        repeat (300) begin
            @(negedge clk_in);
            if (tx_out !== 1'b1 || busy_out !== 1'b0) bad++;
        end
        check("no_partial_after_reset", 64'(bad), 64'd0);
        send_word({$urandom, $urandom}, a);
        wait_ready(1'b0, lc);

        send_word(64'h0000_0000_0000_45FF, a);
        wait_ready(1'b0, lc);

        bad = 0;
        repeat (10000) begin
            @(negedge clk_in);
            if (tx_out !== 1'b1 || busy_out !== 1'b0) bad++;
        end
        check("idle_quiet", 64'(bad), 64'd0);

        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk_in);
            t++;
        end
        check("all_bytes_received", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
